mux_scan_ctrl: RTL and testbench

Sequencer that sits directly upstream of the 4:1 mux and drives its 2-bit select. It steps sel through channels 0..3 and holds each channel for DWELL cycles. On the last dwell cycle of each channel it samples the mux output. After channel 3 it delivers the four samples as a 4-bit frame, in single-shot or continuous mode.

---
 rtl/mux_scan_ctrl_pkg.sv | 14 +
 rtl/mux_dwell_cnt.sv | 27 ++
 rtl/mux_scan_ctrl.sv | 123 ++++++++++++
 tb/tb_mux_scan_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the mux scan sequencer: state encodings, channel count, select width.
package mux_scan_ctrl_pkg;

  localparam int MUX_NCH   = 4;
  localparam int MUX_SEL_W = 2;

  typedef enum logic {
    MUX_ST_IDLE = 1'b0,
    MUX_ST_SCAN = 1'b1
  } state_t;

  localparam logic [MUX_SEL_W-1:0] MUX_SEL_LAST = MUX_SEL_W'(MUX_NCH - 1);

endpackage

// File: rtl/mux_dwell_cnt.sv
// Dwell timer: counts 0..DWELL-1 while enabled, flags the last cycle of each dwell with tc.
module mux_dwell_cnt #(
  parameter int DWELL = 4,
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt;

  assign tc = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer driving a 4:1 mux select; samples each channel at the end of its dwell and
// publishes a 4-bit frame. Optional MUX_SCAN_PARITY_EN adds a registered frame parity output.
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic                 stop,
  input  logic                 mux_out,
  output logic [MUX_SEL_W-1:0] sel,
  output logic                 busy,
  output logic [MUX_NCH-1:0]   frame,
  output logic                 frame_valid
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic                 frame_par
`endif
);

  state_t               state, state_nxt;
  logic [MUX_SEL_W-1:0] sel_nxt;
  logic                 busy_nxt;
  logic [MUX_NCH-1:0]   frame_nxt;
  logic                 frame_valid_nxt;
  logic [MUX_NCH-2:0]   shadow, shadow_nxt;
  logic                 stop_pending, stop_pending_nxt;
  logic                 cnt_clear, cnt_en, tc;

  mux_dwell_cnt #(
    .DWELL (DWELL),
    .CNT_W (CNT_W)
  ) u_dwell_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .en    (cnt_en),
    .tc    (tc)
  );

  always_comb begin
    state_nxt        = state;
    sel_nxt          = sel;
    busy_nxt         = busy;
    frame_nxt        = frame;
    frame_valid_nxt  = 1'b0;
    shadow_nxt       = shadow;
    stop_pending_nxt = stop_pending;
    cnt_clear        = 1'b1;
    cnt_en           = 1'b0;
    unique case (state)
      MUX_ST_IDLE: begin
        // A stop arriving together with start forces a single frame.
        if (start) begin
          state_nxt        = MUX_ST_SCAN;
          busy_nxt         = 1'b1;
          sel_nxt          = '0;
          stop_pending_nxt = stop;
        end
      end
      MUX_ST_SCAN: begin
        cnt_clear = 1'b0;
        cnt_en    = 1'b1;
        if (stop) stop_pending_nxt = 1'b1;
        if (tc) begin
          if (sel == MUX_SEL_LAST) begin
            frame_nxt       = {mux_out, shadow};
            frame_valid_nxt = 1'b1;
            sel_nxt         = '0;
            if (!(mode && !stop_pending)) begin
              state_nxt        = MUX_ST_IDLE;
              busy_nxt         = 1'b0;
              stop_pending_nxt = 1'b0;
            end
          end else begin
            case (sel)
              2'd0:    shadow_nxt[0] = mux_out;
              2'd1:    shadow_nxt[1] = mux_out;
              default: shadow_nxt[2] = mux_out;
            endcase
            sel_nxt = sel + 1'b1;
          end
        end
      end
      default: state_nxt = MUX_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= MUX_ST_IDLE;
      sel          <= '0;
      busy         <= 1'b0;
      frame        <= '0;
      frame_valid  <= 1'b0;
      shadow       <= '0;
      stop_pending <= 1'b0;
    end else begin
      state        <= state_nxt;
      sel          <= sel_nxt;
      busy         <= busy_nxt;
      frame        <= frame_nxt;
      frame_valid  <= frame_valid_nxt;
      shadow       <= shadow_nxt;
      stop_pending <= stop_pending_nxt;
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_par <= 1'b0;
    end else if (frame_valid_nxt) begin
      frame_par <= ^frame_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: DWELL=4 and DWELL=1 instances checked every cycle against a timing model.
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  logic rst, start, mode, stop;
  logic [3:0] in_a, in_b;
  logic [1:0] sel_a, sel_b;
  logic busy_a, busy_b, fv_a, fv_b, mux_a, mux_b;
  logic [3:0] frame_a, frame_b;
`ifdef MUX_SCAN_PARITY_EN
  logic par_a, par_b;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign mux_a = in_a[sel_a];
  assign mux_b = in_b[sel_b];

  mux_scan_ctrl #(.DWELL(4), .CNT_W(3)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .stop(stop), .mux_out(mux_a),
    .sel(sel_a), .busy(busy_a), .frame(frame_a), .frame_valid(fv_a)
`ifdef MUX_SCAN_PARITY_EN
    , .frame_par(par_a)
`endif
  );

  mux_scan_ctrl #(.DWELL(1), .CNT_W(1)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .stop(stop), .mux_out(mux_b),
    .sel(sel_b), .busy(busy_b), .frame(frame_b), .frame_valid(fv_b)
`ifdef MUX_SCAN_PARITY_EN
    , .frame_par(par_b)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: t counts cycles since the start of the current frame; channel = t / dwell.
  bit         m_act[2];
  int         m_t[2];
  bit         m_sp[2];
  logic [3:0] m_smp[2];
  logic [3:0] m_frame[2];
  bit         m_fv[2];
  bit         m_par[2];

  always @(posedge clk) begin
    logic [3:0] iv;
    int d;
    bit sp_old;
    for (int i = 0; i < 2; i++) begin
      iv = (i == 0) ? in_a : in_b;
      d  = (i == 0) ? 4 : 1;
      m_fv[i] = 1'b0;
      if (rst) begin
        m_act[i] = 1'b0; m_t[i] = 0; m_sp[i] = 1'b0;
        m_smp[i] = '0; m_frame[i] = '0; m_par[i] = 1'b0;
      end else if (!m_act[i]) begin
        if (start) begin
          m_act[i] = 1'b1; m_t[i] = 0; m_sp[i] = stop;
        end
      end else begin
        sp_old = m_sp[i];
        if (stop) m_sp[i] = 1'b1;
        if (m_t[i] % d == d - 1) m_smp[i][m_t[i] / d] = iv[m_t[i] / d];
        if (m_t[i] == 4 * d - 1) begin
          m_frame[i] = m_smp[i];
          m_fv[i]    = 1'b1;
          m_par[i]   = ^m_smp[i];
          if (mode && !sp_old) m_t[i] = 0;
          else begin
            m_act[i] = 1'b0; m_sp[i] = 1'b0; m_t[i] = 0;
          end
        end else begin
          m_t[i]++;
        end
      end
    end
    #1;
    chk("a_sel",   sel_a,   m_act[0] ? m_t[0] / 4 : 0);
    chk("a_busy",  busy_a,  m_act[0]);
    chk("a_frame", frame_a, m_frame[0]);
    chk("a_fv",    fv_a,    m_fv[0]);
    chk("b_sel",   sel_b,   m_act[1] ? m_t[1] : 0);
    chk("b_busy",  busy_b,  m_act[1]);
    chk("b_frame", frame_b, m_frame[1]);
    chk("b_fv",    fv_b,    m_fv[1]);
`ifdef MUX_SCAN_PARITY_EN
    chk("a_par",   par_a,   m_par[0]);
    chk("b_par",   par_b,   m_par[1]);
`endif
  end

  // Start pulse; afterwards the caller sits just after edge 0 of the scan.
  task automatic go(input logic m, input logic s);
    @(negedge clk);
    start = 1'b1; mode = m; stop = s;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; stop = 1'b0;
    in_a = 4'b1101;
    in_b = 4'b0110;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_sel", sel_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_frame", frame_a, 0);
    chk("rst_fv", fv_a, 0);

    // single frame
    go(1'b0, 1'b0);
    chk("s1_busy0", busy_a, 1);
    adv(4);  chk("s1_sel4", sel_a, 1);
    adv(4);  chk("s1_sel8", sel_a, 2);
    adv(4);  chk("s1_sel12", sel_a, 3);
    adv(4);  chk("s1_frame", frame_a, 4'b1101); chk("s1_fv", fv_a, 1); chk("s1_busy", busy_a, 0);
    adv(1);  chk("s1_fv_off", fv_a, 0);
    adv(4);

    // continuous, channel 2 flips during frame 2, then stop
    go(1'b1, 1'b0);
    adv(16); chk("s2_f1", frame_a, 4'b1101); chk("s2_fv1", fv_a, 1);
    adv(4);
    @(negedge clk); in_a[2] = 1'b0;
    adv(12); chk("s2_f2", frame_a, 4'b1001); chk("s2_fv2", fv_a, 1); chk("s2_busy", busy_a, 1);
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    adv(15); chk("s2_f3", frame_a, 4'b1001); chk("s2_fv3", fv_a, 1); chk("s2_end", busy_a, 0);
    @(negedge clk); in_a = 4'b1101;
    adv(4);

    // stop at cycle 5 of continuous scan
    go(1'b1, 1'b0);
    adv(4);
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    adv(11); chk("s3_frame", frame_a, 4'b1101); chk("s3_fv", fv_a, 1); chk("s3_busy", busy_a, 0);
    adv(16); chk("s3_no2nd", fv_a, 0); chk("s3_idle", busy_a, 0);

    // reset mid-scan
    go(1'b0, 1'b0);
    adv(9);
    @(negedge clk); rst = 1'b1;
    adv(1);  chk("s4_sel", sel_a, 0); chk("s4_busy", busy_a, 0); chk("s4_frame", frame_a, 0);
    @(negedge clk); rst = 1'b0;
    adv(20); chk("s4_frame_hold", frame_a, 0); chk("s4_fv", fv_a, 0);

    // start re-pulsed while busy
    go(1'b0, 1'b0);
    adv(5);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    adv(2);  chk("s5_sel8", sel_a, 2);
    adv(8);  chk("s5_frame", frame_a, 4'b1101); chk("s5_fv", fv_a, 1); chk("s5_busy", busy_a, 0);
    adv(4);

    // DWELL=1 continuous
    go(1'b1, 1'b0);
    adv(4);  chk("s6_f1", frame_b, 4'b0110); chk("s6_fv1", fv_b, 1);
    adv(4);  chk("s6_f2", frame_b, 4'b0110);
`ifdef MUX_SCAN_PARITY_EN
    chk("s6_par0", par_b, 0);
`endif
    @(negedge clk); in_b = 4'b0111;
    adv(4);  chk("s6_f3", frame_b, 4'b0111); chk("s6_fv3", fv_b, 1);
`ifdef MUX_SCAN_PARITY_EN
    chk("s6_par1", par_b, 1);
`endif
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    adv(20); chk("s6_idle_a", busy_a, 0); chk("s6_idle_b", busy_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
